// File: rtl/branch_trace_gen.sv
// Branch-outcome record generator: emits {pc, taken} records over valid/ready
// in one of four patterns (always-taken, loop, alternate, LFSR-random).
module branch_trace_gen #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned LOOP_W    = 8,
  parameter int unsigned CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [PC_W-1:0]   base_pc,
  input  logic [LOOP_W-1:0] loop_len,
  input  logic [CNT_W-1:0]  num_branches,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_taken,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  taken_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] M_ALWAYS    = 2'd0;
  localparam logic [1:0] M_LOOP      = 2'd1;
  localparam logic [1:0] M_ALTERNATE = 2'd2;
  localparam logic [1:0] M_RANDOM    = 2'd3;

  logic [1:0]        state;
  logic [1:0]        mode_q;
  logic [PC_W-1:0]   base_q;
  logic [LOOP_W-1:0] loop_last_q;
  logic [CNT_W-1:0]  num_last_q;
  logic [CNT_W-1:0]  idx_q;
  logic [LOOP_W-1:0] loop_cnt_q;
  logic [15:0]       lfsr_q;

  logic              xfer;
  logic              rec_taken;
  logic [PC_W-1:0]   rec_pc;
  logic [PC_W-1:0]   pc_offset;
  logic [15:0]       lfsr_next;

  assign out_valid = (state == S_RUN);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign xfer      = out_valid & out_ready;

  assign pc_offset = PC_W'(idx_q[1:0]);
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // NOTE: every output of always_comb gets a default first so no path can infer a latch.
  always_comb begin
    rec_pc    = base_q;
    rec_taken = 1'b1;
    case (mode_q)
      M_ALWAYS:    rec_taken = 1'b1;
      M_LOOP:      rec_taken = (loop_cnt_q != loop_last_q);
      M_ALTERNATE: begin
        rec_pc    = base_q + pc_offset;
        rec_taken = ~idx_q[0];
      end
      M_RANDOM:    begin
        rec_pc    = base_q + pc_offset;
        rec_taken = lfsr_q[0];
      end
      default:     rec_taken = 1'b1;
    endcase
  end

  // Record fields are forced to zero outside RUN; inside RUN they depend only on
  // registers, so they hold steady for as long as the consumer stalls.
  assign out_pc    = out_valid ? rec_pc : '0;
  assign out_taken = out_valid & rec_taken;

  // NOTE: state uses non-blocking assignments under an asynchronous active-low reset,
  // so every register updates together at the edge and a reset aborts a run at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      mode_q      <= M_ALWAYS;
      base_q      <= '0;
      loop_last_q <= '0;
      num_last_q  <= '0;
      idx_q       <= '0;
      loop_cnt_q  <= '0;
      lfsr_q      <= LFSR_SEED;
      taken_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q      <= mode;
            base_q      <= base_pc;
            // Store L-1 with L = max(loop_len, 1) so the compare needs no clamp later.
            loop_last_q <= (loop_len == '0) ? '0 : loop_len - LOOP_W'(1);
            num_last_q  <= num_branches - CNT_W'(1);
            idx_q       <= '0;
            loop_cnt_q  <= '0;
            lfsr_q      <= LFSR_SEED;
            taken_count <= '0;
            state       <= (num_branches == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (xfer) begin
            taken_count <= taken_count + CNT_W'(out_taken);
            idx_q       <= idx_q + CNT_W'(1);
            loop_cnt_q  <= (loop_cnt_q == loop_last_q) ? '0 : loop_cnt_q + LOOP_W'(1);
            lfsr_q      <= lfsr_next;
            if (idx_q == num_last_q) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_trace_gen.sv
// Directed bench for branch_trace_gen: expected records are queued at each start
// and popped by a monitor as the DUT transfers them.
module tb_branch_trace_gen;

  typedef struct packed {
    logic [7:0] pc;
    logic       taken;
  } rec_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  base_pc;
  logic [7:0]  loop_len;
  logic [15:0] num_branches;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_pc;
  logic        out_taken;
  logic        busy;
  logic        done;
  logic [15:0] taken_count;

  int   checks   = 0;
  int   failures = 0;
  int   xfer_count = 0;
  int   done_seen  = 0;
  rec_t exp_q[$];
  bit   stalled = 0;
  rec_t held;

  branch_trace_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .mode         (mode),
    .base_pc      (base_pc),
    .loop_len     (loop_len),
    .num_branches (num_branches),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_taken    (out_taken),
    .busy         (busy),
    .done         (done),
    .taken_count  (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: builds the whole run up front from the record definitions.
  task automatic push_run(input logic [1:0] m, input logic [7:0] b, input logic [7:0] l,
                          input int n, output int tc);
    logic [15:0] lfsr;
    int          lim;
    rec_t        r;
    lfsr = 16'hACE1;
    lim  = (l == 8'd0) ? 1 : int'(l);
    tc   = 0;
    for (int i = 0; i < n; i++) begin
      r.pc = b;
      case (m)
        2'd0: r.taken = 1'b1;
        2'd1: r.taken = ((i % lim) != (lim - 1));
        2'd2: begin r.pc = b + 8'(i & 3); r.taken = ((i & 1) == 0); end
        default: begin
          r.pc    = b + 8'(i & 3);
          r.taken = lfsr[0];
          lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
      endcase
      if (r.taken) tc++;
      exp_q.push_back(r);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of cycle T+1 after the start edge T.
  task automatic start_run(input logic [1:0] m, input logic [7:0] b, input logic [7:0] l,
                           input logic [15:0] n);
    mode = m; base_pc = b; loop_len = l; num_branches = n;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Latency k counts negedges from cycle T+1 (k=1) to the one where done is seen.
  task automatic wait_done(input int budget, input bit rand_rdy, output int lat);
    bit found;
    found = 0;
    lat   = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (done) begin
        lat   = k;
        found = 1;
        break;
      end
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    check("done_seen_in_budget", 32'(found), 32'd1);
    if (found) begin
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_pc", 32'(out_pc), 32'(held.pc));
        check("hold_taken", 32'(out_taken), 32'(held.taken));
      end
      if (out_valid && out_ready) begin
        xfer_count++;
        check("record_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          rec_t e;
          e = exp_q.pop_front();
          check("rec_pc", 32'(out_pc), 32'(e.pc));
          check("rec_taken", 32'(out_taken), 32'(e.taken));
        end
      end
      stalled = out_valid && !out_ready;
      held    = '{pc: out_pc, taken: out_taken};
      if (done) done_seen++;
    end
  end

  initial begin
    int tc;
    int lat;
    int x0;
    int d0;
    bit hit;

    reset_n = 1'b0; start = 1'b0; mode = 2'd0; base_pc = 8'd0;
    loop_len = 8'd0; num_branches = 16'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc", 32'(out_pc), 32'd0);
    check("rst_taken", 32'(out_taken), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_taken_count", 32'(taken_count), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: LOOP len 4, 8 records, ready held high
    out_ready = 1'b1;
    x0 = xfer_count;
    push_run(2'd1, 8'h40, 8'd4, 8, tc);
    start_run(2'd1, 8'h40, 8'd4, 16'd8);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_valid", 32'(out_valid), 32'd1);
    wait_done(50, 1'b0, lat);
    check("t1_done_latency", 32'(lat), 32'd9);
    check("t1_taken_count", 32'(taken_count), 32'd6);
    check("t1_xfers", 32'(xfer_count - x0), 32'd8);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: ALWAYS 3 records, 3-cycle stall mid-run, ignored start while running
    x0 = xfer_count;
    push_run(2'd0, 8'h22, 8'd0, 3, tc);
    start_run(2'd0, 8'h22, 8'd0, 16'd3);
    @(posedge clk);
    #1 out_ready = 1'b0;
    start = 1'b1; mode = 2'd3; base_pc = 8'h99; num_branches = 16'd20;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(50, 1'b0, lat);
    check("t2_xfers", 32'(xfer_count - x0), 32'd3);
    check("t2_taken_count", 32'(taken_count), 32'd3);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: zero-length run
    x0 = xfer_count;
    start_run(2'd0, 8'h10, 8'd0, 16'd0);
    check("t3_done_t1", 32'(done), 32'd1);
    check("t3_valid", 32'(out_valid), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    wait_done(10, 1'b0, lat);
    check("t3_done_latency", 32'(lat), 32'd1);
    check("t3_taken_count", 32'(taken_count), 32'd0);
    check("t3_xfers", 32'(xfer_count - x0), 32'd0);

    // 4: ALTERNATE with pc wrap
    push_run(2'd2, 8'hFE, 8'd0, 5, tc);
    start_run(2'd2, 8'hFE, 8'd0, 16'd5);
    wait_done(50, 1'b0, lat);
    check("t4_taken_count", 32'(taken_count), 32'd3);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: RANDOM 32 records with random backpressure
    push_run(2'd3, 8'h80, 8'd0, 32, tc);
    start_run(2'd3, 8'h80, 8'd0, 16'd32);
    wait_done(400, 1'b1, lat);
    out_ready = 1'b1;
    check("t5_taken_count", 32'(taken_count), 32'(tc));
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6: reset after 2 of 10 transfers, then replay
    x0 = xfer_count;
    push_run(2'd3, 8'h30, 8'd0, 10, tc);
    start_run(2'd3, 8'h30, 8'd0, 16'd10);
    hit = 0;
    for (int k = 0; k < 20; k++) begin
      if (xfer_count - x0 >= 2) begin
        hit = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("t6_reached_two", 32'(hit), 32'd1);
    d0 = done_seen;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_pc", 32'(out_pc), 32'd0);
    check("t6_rst_taken", 32'(out_taken), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_taken_count", 32'(taken_count), 32'd0);
    check("t6_xfers_before_rst", 32'(xfer_count - x0), 32'd2);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_done", 32'(done_seen - d0), 32'd0);
    check("t6_idle_valid", 32'(out_valid), 32'd0);
    push_run(2'd3, 8'h30, 8'd0, 10, tc);
    start_run(2'd3, 8'h30, 8'd0, 16'd10);
    wait_done(50, 1'b0, lat);
    check("t6_taken_count", 32'(taken_count), 32'(tc));
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    // 7: LOOP with loop_len 0
    push_run(2'd1, 8'h55, 8'd0, 4, tc);
    start_run(2'd1, 8'h55, 8'd0, 16'd4);
    wait_done(50, 1'b0, lat);
    check("t7_taken_count", 32'(taken_count), 32'd0);
    check("t7_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
